// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-master memory arbiter.
//   state_t      FSM states (IDLE, ACCESS, DONE), encoding visible on state_o
//   NUM_MASTERS  number of bus masters sharing the memory port
//   owner_t      index of the master owning the current transaction
//   owner_onehot helper turning an owner index into a one-hot grant vector
// Optional feature macro used by the arbiter: MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_MASTERS)-1:0] owner_t;

    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t o);
        logic [NUM_MASTERS-1:0] v;
        v    = '0;
        v[o] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_select.sv
// arb_select: combinational winner picker for the memory arbiter.
//   req          request vector, bit i = master i
//   last_winner  master granted most recently (only used for round-robin)
//   gnt          one-hot grant, all zero when nobody requests
// Macro MEM_ARBITER_RR_EN: defined -> round-robin on ties,
// undefined -> fixed priority with master 0 winning every tie.
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_winner,
    output logic [NUM_MASTERS-1:0] gnt
);

`ifndef MEM_ARBITER_RR_EN
    // Fixed priority ignores history; the port stays for a uniform interface.
    logic unused_last;
    assign unused_last = last_winner;
`endif

    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
`ifdef MEM_ARBITER_RR_EN
            // Tie: hand the port to whichever master did not win last time.
            gnt = last_winner ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between master 0
// (processor) and master 1 (boot loader / DMA).
//   clk, reset_i                 clock, asynchronous active-high reset
//   mN_req_i/we_i/addr_i/data_i  master N transaction request
//   mN_ack_o, mN_data_o          one-cycle completion strobe and read data
//   gnt_o                        one-hot owner while ACCESS/DONE, 0 in IDLE
//   busy_o                       high whenever the FSM is not IDLE
//   state_o                      current FSM state (debug)
//   mem_addr_o/we_o/data_o       registered memory port
//   mem_data_i                   memory read data, valid the cycle after ACCESS
// Macro MEM_ARBITER_RR_EN selects round-robin tie breaking (default: fixed
// priority, master 0 wins).
//
// Handshake: a master raises req with we/addr/data stable and holds them until
// its ack, which is high for exactly one cycle (DONE). A req still high after
// the ack is a fresh request. Each transaction is IDLE -> ACCESS -> DONE, so
// ack arrives two cycles after the grant edge and at most one is outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic [1:0]        gnt_o,
    output logic              busy_o,
    output logic [1:0]        state_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    state_t                 state;
    owner_t                 owner;
    logic                   txn_we;   // kept so DONE knows read vs write after mem_we_o drops
    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] win;
    logic                   last_winner;

    assign req_vec = {m1_req_i, m0_req_i};

`ifndef MEM_ARBITER_RR_EN
    assign last_winner = 1'b1;
`endif

    arb_select u_arb_select (
        .req         (req_vec),
        .last_winner (last_winner),
        .gnt         (win)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            owner      <= '0;
            txn_we     <= 1'b0;
            mem_addr_o <= '0;
            mem_we_o   <= 1'b0;
            mem_data_o <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_winner <= 1'b1;   // makes master 0 win the first tie
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        owner      <= win[1];
                        txn_we     <= win[1] ? m1_we_i   : m0_we_i;
                        mem_we_o   <= win[1] ? m1_we_i   : m0_we_i;
                        mem_addr_o <= win[1] ? m1_addr_i : m0_addr_i;
                        mem_data_o <= win[1] ? m1_data_i : m0_data_i;
`ifdef MEM_ARBITER_RR_EN
                        last_winner <= win[1];
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory commits on this edge; the strobe must not linger.
                    mem_we_o <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_we_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state != IDLE);
    assign state_o   = state;
    assign gnt_o     = busy_o ? owner_onehot(owner) : 2'b00;
    assign m0_ack_o  = (state == DONE) && (owner == 1'b0);
    assign m1_ack_o  = (state == DONE) && (owner == 1'b1);
    assign m0_data_o = (m0_ack_o && !txn_we) ? mem_data_i : '0;
    assign m1_data_o = (m1_ack_o && !txn_we) ? mem_data_i : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port synchronous on-chip memory between the processor (master 0) and a second bus master such as a UART boot loader or DMA engine (master 1). It accepts a request/acknowledge transaction from each master, selects one winner per transaction, and drives the memory port from registered outputs. It completes the read or write with a one-cycle acknowledge carrying read data. It sits between the masters and the memory, ahead of the SoC address decoder's memory branch.

## Interface
- ADDR_W, 32, byte-address width, passed to memory unchanged; the SoC applies the word shift.
- DATA_W, 32, data width.
- clk  in  1  system clock; all state changes on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- m0_req_i, m1_req_i  in  1  transaction request; held high until the matching ack.
- m0_we_i, m1_we_i  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr_i, m1_addr_i  in  ADDR_W  byte address; stable while req is high.
- m0_data_i, m1_data_i  in  DATA_W  write data; stable while req is high.
- m0_ack_o, m1_ack_o  out  1  one-cycle completion strobe.
- m0_data_o, m1_data_o  out  DATA_W  read data; valid only when the corresponding ack is high, 0 otherwise.
- gnt_o  out  2  one-hot current owner in ACCESS/DONE; 0 in IDLE.
- busy_o  out  1  high when state is not IDLE.
- mem_addr_o  out  ADDR_W  registered memory address.
- mem_we_o  out  1  registered write enable; high only in ACCESS for write transactions.
- mem_data_o  out  DATA_W  registered write data.
- mem_data_i  in  DATA_W  memory read data; valid the cycle after the address is sampled.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req: stay in IDLE.
  - Otherwise pick a winner per the arbitration policy. Register owner, mem_addr_o, mem_data_o, and mem_we_o (= winner's we_i), then go to ACCESS.
- ACCESS: memory samples address/we/data at the edge ending this state. Always go to DONE.
- DONE:
  - ack of the owner = 1. Its data_o = mem_data_i for reads and 0 for writes.
  - mem_we_o cleared. Always go to IDLE.
- ack_o and data_o are decoded from state and owner. They are never high for the non-owner.
- A master whose req stays high after its ack is treated as a new request in the next IDLE (back-to-back allowed).
- Only one transaction is outstanding at a time. A losing master's req simply waits; there is no time-out.
- A req deasserted before its ack is a protocol violation. The latched transaction still completes and acks.

## Timing
- Reset values: state IDLE, owner 0, gnt_o 0, busy_o 0, all acks 0, all data_o 0, mem_addr_o 0, mem_we_o 0, mem_data_o 0, last-winner register = 1.
- Latency: req sampled high in IDLE at edge N; ACCESS during cycle N+1; ack high during cycle N+2.
- Throughput: one transaction per 3 cycles.
- Simultaneous requests in IDLE: exactly one is granted; the other is served next.
- Reset asserted mid-transaction: immediately IDLE, mem_we_o = 0, no ack is issued. A write is committed only if its ACCESS-ending edge already occurred.
- Reset released: the first grant can occur at the first rising edge with reset low.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin.
  - On a tie, the master that did not win last is granted.
  - The last-winner register updates on every grant.
  - After reset, master 0 wins the first tie.
- Not defined: fixed priority.
  - Master 0 always wins ties.
  - The last-winner register is absent.
  - Master 1 can be starved by continuous master-0 traffic.

## Structure
- Package mem_arbiter_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - NUM_MASTERS = 2;
  - owner index type.
- Sub-module arb_select: combinational winner picker. Inputs are the request vector and last winner; output is the one-hot grant. The RR/fixed-priority macro applies inside it.
- The top level holds the FSM, latched transaction registers and ack/data muxing.

## Test plan
- Master 0 writes 0xDEADBEEF to 0x10 and master 1 reads 0x10 afterwards. m0_ack at cycle N+2; m1_data_o = 0xDEADBEEF with m1_ack; mem_we_o high exactly one cycle.
- Both reqs rise in the same cycle with RR_EN and both are held for 4 transactions. Grant order m0, m1, m0, m1; acks never overlap.
- Same stimulus without RR_EN: m0 acked all 4 times and m1 never while m0 is held; m1 is acked in the first grant after m0 drops.
- reset_i pulsed during ACCESS of a write of 0x12345678 to 0x20. No ack, mem_we_o drops at once, busy_o = 0; a readback of 0x20 returns the old value.
- Master 1 holds req continuously for back-to-back reads of 0x0, 0x4 and 0x8. Acks spaced 3 cycles apart with the correct data; gnt_o = 2'b10 in each ACCESS/DONE pair.
